// File: rtl/ckpt_pkg.sv
// rtl/ckpt_pkg.sv - register map, status layout and shared types for the checkpoint transmitter
package ckpt_pkg;

  localparam logic [3:0] CKPT_DATA   = 4'h0;
  localparam logic [3:0] CKPT_HOLD   = 4'h4;
  localparam logic [3:0] CKPT_CTRL   = 4'h8;
  localparam logic [3:0] CKPT_STATUS = 4'hC;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int ST_LVL_LSB = 0;
  localparam int ST_FULL    = 4;
  localparam int ST_EMPTY   = 5;
  localparam int ST_BUSY    = 6;
  localparam int ST_OVF     = 7;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ckpt_state_t;

  typedef logic [15:0] ckpt_code_t;

endpackage

// File: rtl/ckpt_fifo.sv
// rtl/ckpt_fifo.sv - synchronous code FIFO with wrap-bit pointers and flush
module ckpt_fifo
  import ckpt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     flush,
  input  logic                     push,
  input  ckpt_code_t               push_data,
  input  logic                     pop,
  output ckpt_code_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  ckpt_code_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot on the same edge, so a push into a full FIFO is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_ckpt_tx.sv
// rtl/wb_ckpt_tx.sv - Wishbone checkpoint transmitter onto mprj_io[31:16]; CKPT_TGL_EN adds ckpt_tgl
module wb_ckpt_tx
  import ckpt_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] HOLD_RST  = 16'd64
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] ckpt_out,
  output logic [15:0] ckpt_oeb,
  output logic        ckpt_tgl
);

  localparam int AW = $clog2(DEPTH);

  logic          hit;
  logic          acc;
  logic          wr;
  logic          rd;
  logic [3:0]    off;
  logic          clr;
  logic          push;
  logic          pop;
  logic          load;
  logic          en;
  logic          ovf;
  ckpt_code_t    hold_reg;
  ckpt_code_t    cnt;
  ckpt_code_t    cnt_nxt;
  ckpt_code_t    out_nxt;
  ckpt_state_t   state;
  ckpt_state_t   state_nxt;
  ckpt_code_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   level;
  logic [31:0]   rdata;
  logic [7:0]    status;
  logic          unused_bits;

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // A transfer is accepted only while ack is low, so ack can never assert twice in a row.
  assign hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign acc  = hit & ~wbs_ack_o;
  assign wr   = acc & wbs_we_i;
  assign rd   = acc & ~wbs_we_i;
  assign off  = {wbs_adr_i[3:2], 2'b00};

  assign clr  = wr & (off == CKPT_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
  assign push = wr & (off == CKPT_DATA) & (|wbs_sel_i[1:0]);

  ckpt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .flush     (clr),
    .push      (push),
    .push_data (wbs_dat_i[15:0]),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    status                           = '0;
    status[ST_LVL_LSB +: 4]          = 4'(level);
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_BUSY]                  = (state != IDLE);
    status[ST_OVF]                   = ovf;
    rdata                            = '0;
    case (off)
      CKPT_HOLD:   rdata = {16'h0000, hold_reg};
      CKPT_CTRL:   rdata = {31'h0, en};
      CKPT_STATUS: rdata = {24'h0, status};
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ckpt_oeb  <= 16'hFFFF;
      en        <= 1'b0;
      ovf       <= 1'b0;
      hold_reg  <= HOLD_RST;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : '0;
      ckpt_oeb  <= en ? 16'h0000 : 16'hFFFF;
      if (clr)                                 ovf <= 1'b0;
      else if (push && fifo_full && !pop)      ovf <= 1'b1;
      else if (rd && (off == CKPT_STATUS))     ovf <= 1'b0;
      if (wr && (off == CKPT_HOLD)) begin
        if (wbs_sel_i[0]) hold_reg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) hold_reg[15:8] <= wbs_dat_i[15:8];
      end
      if (wr && (off == CKPT_CTRL) && wbs_sel_i[0]) en <= wbs_dat_i[CTRL_EN];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      cnt      <= '0;
      ckpt_out <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ckpt_out <= out_nxt;
    end
  end

  // cnt holds the remaining extra cycles; a code is loaded again when it reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = ckpt_out;
    pop       = 1'b0;
    load      = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      out_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !fifo_empty) load = 1'b1;
        end
        HOLD: begin
          if (cnt == '0) begin
            if (en && !fifo_empty) load = 1'b1;
            else                   state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (load) begin
        pop       = 1'b1;
        out_nxt   = head;
        cnt_nxt   = (hold_reg == '0) ? '0 : hold_reg - 16'd1;
        state_nxt = HOLD;
      end
    end
  end

`ifdef CKPT_TGL_EN
  logic tgl;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)   tgl <= 1'b0;
    else if (load) tgl <= ~tgl;
  end

  assign ckpt_tgl = tgl;
`else
  assign ckpt_tgl = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ckpt_tx.sv
// tb/tb_wb_ckpt_tx.sv - randomized bench for wb_ckpt_tx against a timeline reference model
module tb_wb_ckpt_tx;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        bus_cyc = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_sel = 4'hF;
  logic [31:0] bus_adr = '0;
  logic [31:0] bus_dat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] ckpt_out;
  logic [15:0] ckpt_oeb;
  logic        ckpt_tgl;

  int checks = 0;
  int failures = 0;

  wb_ckpt_tx dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs_cyc_i (bus_cyc),
    .wbs_stb_i (bus_stb),
    .wbs_we_i  (bus_we),
    .wbs_sel_i (bus_sel),
    .wbs_adr_i (bus_adr),
    .wbs_dat_i (bus_dat),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .ckpt_out  (ckpt_out),
    .ckpt_oeb  (ckpt_oeb),
    .ckpt_tgl  (ckpt_tgl)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: codes wait in a queue; a code may be shown once the previous one has
  // been on the pins for max(HOLD,1) cycles (m_free is the first edge a new load is allowed).
  logic [15:0] mq[$];
  logic        m_en = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_hold = 16'd64;
  logic        m_ack = 1'b0;
  logic [31:0] m_dat = '0;
  logic [15:0] m_out = '0;
  logic [15:0] m_oeb = 16'hFFFF;
  logic        m_tgl = 1'b0;
  int          m_free = 0;
  int          k = 0;
  logic        m_hit, m_acc, m_wr, m_rd, m_clr;
  logic [1:0]  m_off;
  logic [7:0]  m_st;

  always @(posedge clock) begin
    if (!resetb) begin
      mq.delete();
      m_en = 1'b0; m_ovf = 1'b0; m_hold = 16'd64; m_ack = 1'b0; m_dat = '0;
      m_out = '0; m_oeb = 16'hFFFF; m_tgl = 1'b0; m_free = 0;
    end else begin
      k++;
      m_hit = bus_cyc && bus_stb && ((bus_adr & 32'hFFFF_FFF0) == BASE);
      m_acc = m_hit && !m_ack;
      m_wr  = m_acc && bus_we;
      m_rd  = m_acc && !bus_we;
      m_off = bus_adr[3:2];
      m_st  = {m_ovf, (k <= m_free), (mq.size() == 0), (mq.size() == DEPTH), 4'(mq.size())};
      m_dat = '0;
      if (m_rd) begin
        case (m_off)
          2'd1: m_dat = {16'h0, m_hold};
          2'd2: m_dat = {31'h0, m_en};
          2'd3: m_dat = {24'h0, m_st};
          default: m_dat = '0;
        endcase
      end
      m_oeb = m_en ? 16'h0000 : 16'hFFFF;
      m_clr = m_wr && (m_off == 2'd2) && bus_dat[1];
      if (m_clr) begin
        mq.delete();
        m_out = '0; m_free = 0; m_ovf = 1'b0;
      end else begin
        if (m_en && mq.size() > 0 && k >= m_free) begin
          m_out = mq.pop_front();
          m_free = k + ((m_hold == 0) ? 1 : int'(m_hold));
          m_tgl = ~m_tgl;
        end
        if (m_wr && m_off == 2'd0) begin
          if (mq.size() < DEPTH) mq.push_back(bus_dat[15:0]);
          else m_ovf = 1'b1;
        end
      end
      if (m_rd && m_off == 2'd3) m_ovf = 1'b0;
      if (m_wr && m_off == 2'd1) m_hold = bus_dat[15:0];
      if (m_wr && m_off == 2'd2) m_en = bus_dat[0];
      m_ack = m_acc;
      #1;
      chk("ack", {31'h0, wbs_ack_o}, {31'h0, m_ack});
      chk("dat_o", wbs_dat_o, m_dat);
      chk("ckpt_out", {16'h0, ckpt_out}, {16'h0, m_out});
      chk("ckpt_oeb", {16'h0, ckpt_oeb}, {16'h0, m_oeb});
`ifdef CKPT_TGL_EN
      chk("ckpt_tgl", {31'h0, ckpt_tgl}, {31'h0, m_tgl});
`else
      chk("ckpt_tgl", {31'h0, ckpt_tgl}, 32'h0);
`endif
    end
  end

  task automatic bus(input logic we, input logic [3:0] off, input logic [31:0] dat,
                     output logic [31:0] rdat);
    int n = 0;
    bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = we;
    bus_adr = BASE | {28'h0, off}; bus_dat = dat;
    do begin
      @(posedge clock); #1; n++;
    end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) chk("ack_timeout", 32'h0, 32'h1);
    rdat = wbs_dat_o;
    bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, off, dat, d);
  endtask

  task automatic miss(input logic we);
    bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = we;
    bus_adr = BASE + 32'h10 + {28'h0, 2'($urandom), 2'b00};
    bus_dat = $urandom;
    repeat (3) @(posedge clock);
    #1;
    bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out"}, {16'h0, ckpt_out}, 32'h0);
    chk({tag, "_oeb"}, {16'h0, ckpt_oeb}, 32'h0000_FFFF);
    chk({tag, "_ack"}, {31'h0, wbs_ack_o}, 32'h0);
    chk({tag, "_dat"}, wbs_dat_o, 32'h0);
    chk({tag, "_tgl"}, {31'h0, ckpt_tgl}, 32'h0);
  endtask

  logic [31:0] rd_val;

  initial begin
    #1 resetb = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clock);
    #3 resetb = 1'b1;
    idle(2);

    // Single code, HOLD=4
    wr(4'h8, 32'h1);
    wr(4'h4, 32'd4);
    wr(4'h0, 32'hAB60);
    idle(1);
    chk("first_latency", {16'h0, ckpt_out}, 32'hAB60);
    chk("oeb_drive", {16'h0, ckpt_oeb}, 32'h0);
    idle(8);

    // Back-to-back codes, HOLD=3
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hAB60);
    wr(4'h0, 32'hAB61);
    wr(4'h0, 32'h0001);
    idle(15);
    chk("last_stays", {16'h0, ckpt_out}, 32'h0001);
    bus(1'b0, 4'hC, 32'h0, rd_val);
    chk("status_empty", rd_val, 32'h20);

    // Overflow with EN=0
    wr(4'h8, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) wr(4'h0, 32'h0100 + i);
    bus(1'b0, 4'hC, 32'h0, rd_val);
    chk("status_ovf", rd_val, 32'h98);
    bus(1'b0, 4'hC, 32'h0, rd_val);
    chk("status_ovf_clr", rd_val, 32'h18);

    // CLR mid-hold
    wr(4'h8, 32'h1);
    idle(2);
    wr(4'h8, 32'h3);
    chk("clr_out", {16'h0, ckpt_out}, 32'h0);
    bus(1'b0, 4'hC, 32'h0, rd_val);
    chk("clr_status", rd_val, 32'h20);
    bus(1'b0, 4'h8, 32'h0, rd_val);
    chk("ctrl_clr_reads0", rd_val, 32'h1);

    // HOLD=0 behaves as 1, then async reset mid-hold
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h0A0A);
    wr(4'h0, 32'h0B0B);
    idle(4);
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h00C1);
    @(posedge clock);
    #3 resetb = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clock);
    #3 resetb = 1'b1;
    idle(1);

    // Identical repeated codes
    wr(4'h8, 32'h1);
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1234);
    wr(4'h0, 32'h1234);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      wr(4'h0, (r < 8) ? 32'h1234 : {16'h0, 16'($urandom)});
      else if (r < 53) wr(4'h4, $urandom_range(0, 5));
      else if (r < 62) wr(4'h8, {30'h0, ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) != 0)});
      else if (r < 82) bus(1'b0, {2'($urandom), 2'b00}, 32'h0, rd_val);
      else if (r < 88) miss(1'($urandom));
      else             idle($urandom_range(1, 6));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
